fft_wb_ctrl: RTL and testbench

FFT_WB_CTRL -- requirements
Module: fft_wb_ctrl

---
 rtl/fft_wb_ctrl_pkg.sv | 13 +
 rtl/fft_wb_ctrl_if.sv | 30 +++
 rtl/fft_bfly_addr_gen.sv | 64 ++++++
 rtl/fft_wb_ctrl.sv | 78 +++++++
 tb/tb_fft_wb_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fft_wb_ctrl_pkg.sv
// Shared FFT write-back definitions: default geometry and controller state encoding.
package fft_wb_ctrl_pkg;
    localparam int FFT_N     = 256;
    localparam int FFT_DW    = 32;
    localparam int FFT_LOG2N = $clog2(FFT_N);

    typedef logic [2:0] state_t;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_WR_A = 3'd2;
    localparam logic [2:0] S_WR_B = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/fft_wb_ctrl_if.sv
// Butterfly result handshake and data-RAM write port of the FFT write-back controller.
interface fft_wb_ctrl_if
    import fft_wb_ctrl_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = FFT_DW
);
    localparam int AW = $clog2(N);

    logic          calc_start;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_a;
    logic [DW-1:0] res_b;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          stage_done;
    logic          calc_done;

    modport master (
        output calc_start, res_valid, res_a, res_b,
        input  res_ready, mem_we, mem_addr, mem_wdata, stage_done, calc_done
    );

    modport slave (
        input  calc_start, res_valid, res_a, res_b,
        output res_ready, mem_we, mem_addr, mem_wdata, stage_done, calc_done
    );
endinterface

// File: rtl/fft_bfly_addr_gen.sv
// Radix-2 butterfly sequencer: k innermost, then group base g, then stage s.
module fft_bfly_addr_gen
    import fft_wb_ctrl_pkg::*;
#(
    parameter int N = FFT_N,
    localparam int AW = $clog2(N),
    localparam int SW = $clog2(AW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [AW-1:0] o_idx1,
    output logic [AW-1:0] o_idx2,
    output logic          o_last_stage,
    output logic          o_last_all
);
    localparam logic [AW:0]   LIM    = N[AW:0];
    localparam logic [AW:0]   ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [SW-1:0] S_LAST = SW'(AW - 1);

    logic [AW:0]   r_k, r_g;
    logic [SW-1:0] r_s;
    logic [AW:0]   w_h, w_h2, w_g_nxt, w_i1, w_i2;
    logic          w_k_last, w_g_last;

    // One extra bit everywhere so g+2h == N is seen as the wrap, not as zero.
    assign w_h      = ONE << r_s;
    assign w_h2     = w_h << 1;
    assign w_g_nxt  = r_g + w_h2;
    assign w_k_last = (r_k == w_h - ONE);
    assign w_g_last = (w_g_nxt >= LIM);
    assign w_i1     = r_g + r_k;
    assign w_i2     = w_i1 + w_h;

    assign o_idx1       = w_i1[AW-1:0];
    assign o_idx2       = w_i2[AW-1:0];
    assign o_last_stage = w_k_last && w_g_last;
    assign o_last_all   = o_last_stage && (r_s == S_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
            r_g <= '0;
            r_s <= '0;
        end else if (i_clr) begin
            r_k <= '0;
            r_g <= '0;
            r_s <= '0;
        end else if (i_adv) begin
            if (w_k_last) begin
                r_k <= '0;
                if (w_g_last) begin
                    r_g <= '0;
                    r_s <= r_s + 1'b1;
                end else begin
                    r_g <= w_g_nxt;
                end
            end else begin
                r_k <= r_k + ONE;
            end
        end
    end
endmodule

// File: rtl/fft_wb_ctrl.sv
// FFT write-back controller: accepts butterfly result pairs and writes them to idx1/idx2.
module fft_wb_ctrl
    import fft_wb_ctrl_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int DW = FFT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    fft_wb_ctrl_if.slave  bus
);
    localparam int AW = $clog2(N);

    state_t        r_state, w_nxt;
    logic [DW-1:0] r_a, r_b;
    logic [AW-1:0] w_idx1, w_idx2;
    logic          w_last_stage, w_last_all;
    logic          w_ready, w_xfer, w_clr, w_wr;

    fft_bfly_addr_gen #(.N(N)) u_addr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_clr),
        .i_adv        (r_state == S_WR_B),
        .o_idx1       (w_idx1),
        .o_idx2       (w_idx2),
        .o_last_stage (w_last_stage),
        .o_last_all   (w_last_all)
    );

    // Ready is a function of state and counters only, never of res_valid.
    assign w_ready = (r_state == S_WAIT) || ((r_state == S_WR_B) && !w_last_all);
    assign w_xfer  = bus.res_valid && w_ready;
    assign w_clr   = (r_state == S_IDLE) || !bus.calc_start;

    always_comb begin
        w_nxt = r_state;
        if (!bus.calc_start) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_nxt = S_WAIT;
                S_WAIT:  w_nxt = w_xfer ? S_WR_A : S_WAIT;
                S_WR_A:  w_nxt = S_WR_B;
                S_WR_B:  w_nxt = w_last_all ? S_DONE : (w_xfer ? S_WR_A : S_WAIT);
                S_DONE:  w_nxt = S_DONE;
                default: w_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_nxt;
            if (!bus.calc_start) begin
                r_a <= '0;
                r_b <= '0;
            end else if (w_xfer) begin
                r_a <= bus.res_a;
                r_b <= bus.res_b;
            end
        end
    end

    // An abort suppresses the write in the very cycle calc_start drops.
    assign w_wr = bus.calc_start && ((r_state == S_WR_A) || (r_state == S_WR_B));

    assign bus.res_ready  = w_ready;
    assign bus.mem_we     = w_wr;
    assign bus.mem_addr   = !w_wr ? '0 : ((r_state == S_WR_B) ? w_idx2 : w_idx1);
    assign bus.mem_wdata  = !w_wr ? '0 : ((r_state == S_WR_B) ? r_b : r_a);
    assign bus.stage_done = w_wr && (r_state == S_WR_B) && w_last_stage;
    assign bus.calc_done  = (r_state == S_DONE);
endmodule

// File: tb/tb_fft_wb_ctrl.sv
// Bench for fft_wb_ctrl: directed vector table, random-gap full transform vs. arithmetic model, corner sequences.
module tb_fft_wb_ctrl;
    localparam int N    = 256;
    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int HALF = N / 2;
    localparam int NBF  = HALF * AW;

    logic clk;
    logic rst_n;

    fft_wb_ctrl_if #(.N(N), .DW(DW)) bus ();
    fft_wb_ctrl #(.N(N), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          cs, v;
        logic [DW-1:0] a, b;
        logic          rdy, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          sd, done;
    } vec_t;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
        bit            sd;
        bit            last;
    } wr_t;

    vec_t tbl[11];
    wr_t  exp_q[$];

    int checks = 0, failures = 0;
    int cyc_no = 0, n_xfer = 0, xfers = 0, writes = 0, sd_cnt = 0;
    int done_cyc = -1, last_we_cyc = -1, last_wr_addr = -1, first_wr_addr = -1;
    bit mon_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Butterfly n of the transform, from the stage/group/offset definitions.
    function automatic void push_bfly(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s, j, h, g, k;
        wr_t e;
        s = n / HALF;
        j = n % HALF;
        h = 1 << s;
        g = (j / h) * 2 * h;
        k = j % h;
        e.addr = g + k;     e.data = a; e.sd = 0;             e.last = 0;
        exp_q.push_back(e);
        e.addr = g + k + h; e.data = b; e.sd = (j == HALF-1); e.last = (n == NBF-1);
        exp_q.push_back(e);
    endfunction

    task automatic check_outputs();
        wr_t e;
        if (bus.mem_we) begin
            writes++;
            if (first_wr_addr < 0) first_wr_addr = int'(bus.mem_addr);
            last_wr_addr = int'(bus.mem_addr);
            last_we_cyc  = cyc_no;
            if (bus.stage_done) sd_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_no_xfer actual addr=%0h required=no write", bus.mem_addr);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
                chk("wr_data", 64'(bus.mem_wdata), 64'(e.data));
                chk("wr_stage_done", 64'(bus.stage_done), 64'(e.sd));
                if (e.last) chk("final_wrb_ready", 64'(bus.res_ready), 64'd0);
            end
        end else begin
            chk("sd_no_write", 64'(bus.stage_done), 64'd0);
        end
        if (bus.calc_done && done_cyc < 0) done_cyc = cyc_no;
    endtask

    task automatic drive(input logic cs, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.calc_start = cs;
        bus.res_valid  = v;
        bus.res_a      = a;
        bus.res_b      = b;
        #1;
    endtask

    task automatic step();
        logic rdy;
        rdy = bus.res_ready;
        if (mon_en) check_outputs();
        @(posedge clk);
        if (mon_en) begin
            if (!bus.calc_start) begin
                exp_q.delete();
                n_xfer = 0;
            end else if (bus.res_valid && rdy) begin
                push_bfly(n_xfer, bus.res_a, bus.res_b);
                n_xfer++;
                xfers++;
            end
        end
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic cyc(input logic cs, input logic v);
        drive(cs, v, $urandom, $urandom);
        step();
    endtask

    function automatic logic [DW-1:0] va(input int i); return 32'hA000_0000 + i; endfunction
    function automatic logic [DW-1:0] vb(input int i); return 32'hB000_0000 + i; endfunction

    initial begin
        int budget;
        // cs v a b | rdy we addr wdata sd done
        tbl[0]  = '{1, 1, va(0),  vb(0),  0, 0, 8'd0, '0,     0, 0};
        tbl[1]  = '{1, 1, va(1),  vb(1),  1, 0, 8'd0, '0,     0, 0};
        tbl[2]  = '{1, 1, va(2),  vb(2),  0, 1, 8'd0, va(1),  0, 0};
        tbl[3]  = '{1, 1, va(3),  vb(3),  1, 1, 8'd1, vb(1),  0, 0};
        tbl[4]  = '{1, 1, va(4),  vb(4),  0, 1, 8'd2, va(3),  0, 0};
        tbl[5]  = '{1, 1, va(5),  vb(5),  1, 1, 8'd3, vb(3),  0, 0};
        tbl[6]  = '{1, 1, va(6),  vb(6),  0, 1, 8'd4, va(5),  0, 0};
        tbl[7]  = '{1, 0, va(7),  vb(7),  1, 1, 8'd5, vb(5),  0, 0};
        tbl[8]  = '{1, 1, va(8),  vb(8),  1, 0, 8'd0, '0,     0, 0};
        tbl[9]  = '{1, 0, va(9),  vb(9),  0, 1, 8'd6, va(8),  0, 0};
        tbl[10] = '{1, 0, va(10), vb(10), 1, 1, 8'd7, vb(8),  0, 0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        chk("rst_outputs", {bus.res_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stage_done, bus.calc_done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stage-0 start-up with a couple of valid gaps.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].cs, tbl[i].v, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d", i),
                {bus.res_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stage_done, bus.calc_done},
                {tbl[i].rdy, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].sd, tbl[i].done});
            step();
        end
        cyc(1'b0, 1'b0);

        // Random run aborted in the middle of stage 3.
        mon_en = 1;
        budget = 0;
        while (n_xfer < 3*HALF + 10 && budget < 5000) begin
            cyc(1'b1, $urandom_range(0, 3) != 0);
            budget++;
        end
        chk("abort_reached_stage3", 64'(n_xfer >= 3*HALF + 10), 64'd1);
        drive(1'b0, 1'b1, $urandom, $urandom);
        chk("abort_we", 64'(bus.mem_we), 64'd0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        chk("abort_idle", {bus.res_ready, bus.mem_we, bus.calc_done}, 64'd0);
        step();

        // Full transform with random valid gaps.
        xfers = 0; writes = 0; sd_cnt = 0; done_cyc = -1; first_wr_addr = -1;
        budget = 0;
        while (done_cyc < 0 && budget < 20000) begin
            cyc(1'b1, $urandom_range(0, 3) != 0);
            budget++;
        end
        chk("full_done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("restart_addr0", 64'(first_wr_addr), 64'd0);
        chk("xfers", 64'(xfers), 64'd1024);
        chk("writes", 64'(writes), 64'd2048);
        chk("stage_done_pulses", 64'(sd_cnt), 64'd8);
        chk("model_drained", 64'(exp_q.size()), 64'd0);
        chk("last_wr_addr", 64'(last_wr_addr), 64'd255);
        chk("done_after_last_wr", 64'(done_cyc - last_we_cyc), 64'd1);

        // DONE holds with calc_start high, clears once it drops.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, $urandom, $urandom);
            chk("done_hold", {bus.calc_done, bus.res_ready, bus.mem_we}, 64'b100);
            step();
        end
        cyc(1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, '0);
        chk("done_cleared", 64'(bus.calc_done), 64'd0);
        step();

        // Asynchronous reset while a write is in flight.
        mon_en = 0;
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        drive(1'b1, 1'b1, 32'h1234_5678, 32'h9abc_def0);
        chk("wra_entered", {bus.mem_we, bus.res_ready}, 64'b10);
        rst_n = 1'b0;
        #1;
        chk("rst_in_wra", {bus.res_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.stage_done, bus.calc_done}, 64'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, $urandom, $urandom);
            chk("rst_no_write", {bus.mem_we, bus.res_ready}, 64'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
